// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift-amount sequencer: shift-stage
// op codes, FSM state encodings and default datapath sizes.
package shift_sequencer_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int SHAMT_W_DEF = 3;

    // Codes understood by the external single-position shift stage.
    // 101..111 are pass-through (the stage returns its operand unchanged).
    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_ROR = 3'b001;
    localparam logic [2:0] OP_LSL = 3'b010;
    localparam logic [2:0] OP_LSR = 3'b011;
    localparam logic [2:0] OP_ASR = 3'b100;

    // Sequencer states.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // True for codes that actually move bits; pass-through codes need no steps.
    function automatic logic is_shift_op(input logic [2:0] code);
        return (code <= OP_ASR);
    endfunction

    // True when the bit leaving the accumulator is the MSB (left-moving ops).
    function automatic logic exits_msb(input logic [2:0] code);
        return (code == OP_ROL) || (code == OP_LSL);
    endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Multi-cycle shift-amount sequencer. Drives an external single-position
// shift stage (sh_a/sh_sel -> sh_y), looping its output back once per clock
// until the requested number of steps is done. The result feeds ALU operand B.
//
// Build option: define SHIFT_CARRY_EN to track the last bit shifted out on
// carry_out; without it carry_out is tied low (port list is the same).
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; result holds the previous value
// S_STEP | one single-position step per clock, cnt counts down to 1
// S_DONE | one-cycle done pulse, result valid from here on
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [2:0]         op,
    output logic [WIDTH-1:0]   sh_a,
    output logic [2:0]         sh_sel,
    input  logic [WIDTH-1:0]   sh_y,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               carry_out
);

    logic [1:0]         state;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] cnt;
    logic [2:0]         op_q;

    // FSM, accumulator and remaining-step counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            op_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc  <= operand;
                        op_q <= op;
                        cnt  <= shamt;
                        // Zero-length or pass-through requests skip straight to DONE.
                        if ((shamt == '0) || !is_shift_op(op))
                            state <= S_DONE;
                        else
                            state <= S_STEP;
                    end
                end
                S_STEP: begin
                    acc <= sh_y;
                    cnt <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SHIFT_CARRY_EN
    logic carry_q;

    // Capture the bit leaving acc on every real step; otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            carry_q <= 1'b0;
        else if (state == S_STEP)
            carry_q <= exits_msb(op_q) ? acc[WIDTH-1] : acc[0];
    end

    assign carry_out = carry_q;
`else
    assign carry_out = 1'b0;
`endif

    assign sh_a   = acc;
    assign sh_sel = op_q;
    assign result = acc;
    assign busy   = (state == S_STEP);
    assign done   = (state == S_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural single-position shift
// stage and a result/carry scoreboard pushed at start and popped at done.
module tb_shift_sequencer;
    import shift_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] operand;
    logic [2:0] shamt;
    logic [2:0] op;
    logic [7:0] sh_a;
    logic [2:0] sh_sel;
    logic [7:0] sh_y;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q_res[$];
    logic       q_car[$];
    logic       carry_model = 1'b0;

    shift_sequencer #(.WIDTH(8), .SHAMT_W(3)) dut (
        .clk(clk), .reset(reset), .start(start), .operand(operand),
        .shamt(shamt), .op(op), .sh_a(sh_a), .sh_sel(sh_sel), .sh_y(sh_y),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    // External single-position shift stage.
    always_comb begin
        sh_y = sh_a;
        case (sh_sel)
            3'b000: sh_y = {sh_a[6:0], sh_a[7]};
            3'b001: sh_y = {sh_a[0], sh_a[7:1]};
            3'b010: sh_y = {sh_a[6:0], 1'b0};
            3'b011: sh_y = {1'b0, sh_a[7:1]};
            3'b100: sh_y = {sh_a[7], sh_a[7:1]};
            default: sh_y = sh_a;
        endcase
    end

    // Whole-amount reference, independent of the step-by-step stage.
    function automatic logic [7:0] ref_shift(input logic [2:0] o, input logic [7:0] a, input int n);
        logic [7:0] r;
        r = a;
        if (n != 0) begin
            case (o)
                3'b000: r = (a << n) | (a >> (8 - n));
                3'b001: r = (a >> n) | (a << (8 - n));
                3'b010: r = a << n;
                3'b011: r = a >> n;
                3'b100: r = 8'($signed(a) >>> n);
                default: r = a;
            endcase
        end
        return r;
    endfunction

    // Last bit shifted out after n whole steps (n >= 1, shift ops only).
    function automatic logic ref_carry(input logic [2:0] o, input logic [7:0] a, input int n);
        if (o == 3'b000 || o == 3'b010)
            return a[8 - n];
        return a[n - 1];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for done, compare against the scoreboard.
    // inject: pulse start with different operands while the step is running.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] a,
                          input logic [2:0] n, input logic [7:0] exp_r, input bit inject);
        int lat;
        int busy_cnt;
        bit shifts;
        logic [7:0] got_r;
        logic       got_c;
        logic [7:0] want_r;
        logic       want_c;
        shifts = (o <= 3'b100) && (n != 3'd0);
`ifdef SHIFT_CARRY_EN
        if (shifts) carry_model = ref_carry(o, a, int'(n));
`endif
        q_res.push_back(exp_r);
        q_car.push_back(carry_model);
        check({tag, "_ref"}, 32'(ref_shift(o, a, int'(n))), 32'(exp_r));
        @(negedge clk);
        op = o; operand = a; shamt = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        operand = 8'($urandom); shamt = 3'($urandom); op = 3'($urandom);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
            if (inject && lat == 1) begin
                start = 1'b1; operand = 8'hFF; op = 3'b010; shamt = 3'd1;
            end else if (inject && lat == 2) begin
                start = 1'b0;
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(lat), shifts ? 32'(n) : 32'd0);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), shifts ? 32'(n) : 32'd0);
        got_r = result;
        got_c = carry_out;
        want_r = q_res.pop_front();
        want_c = q_car.pop_front();
        check({tag, "_result"}, 32'(got_r), 32'(want_r));
        check({tag, "_carry"}, 32'(got_c), 32'(want_c));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_result_held"}, 32'(result), 32'(want_r));
    endtask

    initial begin
        int seen;
        reset = 1'b1; start = 1'b0; operand = '0; shamt = '0; op = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        reset = 1'b0;

        run_op("rol_81_3", OP_ROL, 8'h81, 3'd3, 8'h0C, 1'b0);
        run_op("asr_80_7", OP_ASR, 8'h80, 3'd7, 8'hFF, 1'b0);
        run_op("lsr_80_7", OP_LSR, 8'h80, 3'd7, 8'h01, 1'b0);
        run_op("lsl_c0_1", OP_LSL, 8'hC0, 3'd1, 8'h80, 1'b0);
        run_op("lsl_01_0", OP_LSL, 8'h01, 3'd0, 8'h01, 1'b0);
        run_op("pass_5a_3", 3'b101, 8'h5A, 3'd3, 8'h5A, 1'b0);
        run_op("ror_01_4", OP_ROR, 8'h01, 3'd4, 8'h10, 1'b1);
        run_op("rol_81_7", OP_ROL, 8'h81, 3'd7, 8'hC0, 1'b0);

        // Abort mid-operation with reset: no done, everything cleared.
        @(negedge clk);
        op = OP_LSR; operand = 8'hF0; shamt = 3'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        check("abort_acc_2steps", 32'(result), 32'h3C);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_carry", 32'(carry_out), 32'd0);
        carry_model = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run_op("lsr_f0_5", OP_LSR, 8'hF0, 3'd5, 8'h07, 1'b0);

        check("scoreboard_empty", 32'(q_res.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
